mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/toast_mem_pkg.sv | 9 +
 rtl/rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/toast_mem_pkg.sv
// toast_mem_pkg: shared FSM/port types and read-latency constants for the
// unified-memory arbiter.
package toast_mem_pkg;
    localparam int DATA_W = 32;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick between the I and D ports; the
// last-grant register only advances when the winner is actually latched.
module rr_arb2
    import toast_mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  req_i,
    input  logic  req_d,
    output port_t grant
);
    port_t last_q, last_d;

    always_comb begin
        grant = (req_i && req_d) ? ((last_q == PORT_I) ? PORT_D : PORT_I)
                                 : (req_d ? PORT_D : PORT_I);
        last_d = en ? grant : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= PORT_I;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port, one transaction at a time (IDLE/ISSUE/WAIT/DONE).
module mem_arbiter
    import toast_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic              I_ack,
    output logic [DATA_W-1:0] I_rd_data,
    input  logic              D_req,
    input  logic              D_wr_en,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [3:0]        D_byte_en,
    input  logic [DATA_W-1:0] D_wr_data,
    output logic              D_ack,
    output logic [DATA_W-1:0] D_rd_data,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_byte_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              I_stall,
    output logic              D_stall
);
    state_t            state_q, state_d;
    port_t             port_q, port_d, grant;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              en_q, en_d, wen_q, wen_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rd_q, i_rd_d, d_rd_q, d_rd_d;
    logic              latch, fin;

    rr_arb2 u_arb (
        .clk  (Clk),
        .rst  (Reset),
        .en   (latch),
        .req_i(I_req),
        .req_d(D_req),
        .grant(grant)
    );

    always_comb begin
        latch   = (state_q == IDLE) && (I_req || D_req);
        fin     = (state_q == WAIT) || ((state_q == ISSUE) && (wr_q || RD_LATENCY == RD_LAT_MIN));
        state_d = state_q;
        port_d  = port_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        en_d    = latch;
        wen_d   = latch && (grant == PORT_D) && D_wr_en;
        i_ack_d = fin && (port_q == PORT_I);
        d_ack_d = fin && (port_q == PORT_D);
        i_rd_d  = i_rd_q;
        d_rd_d  = d_rd_q;
        case (state_q)
            IDLE: if (latch) begin
                state_d = ISSUE;
                port_d  = grant;
                wr_d    = wen_d;
                addr_d  = (grant == PORT_D) ? D_addr : I_addr;
                be_d    = (grant == PORT_D) ? D_byte_en : 4'b0000;
                wdata_d = (grant == PORT_D) ? D_wr_data : '0;
            end
            ISSUE: state_d = fin ? DONE : WAIT;
            WAIT:  state_d = DONE;
            DONE: begin
                state_d = IDLE;
                if (!wr_q && port_q == PORT_I) i_rd_d = mem_rd_data;
                if (!wr_q && port_q == PORT_D) d_rd_d = mem_rd_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            port_q  <= PORT_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            wen_q   <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            i_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            wen_q   <= wen_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
            i_rd_q  <= i_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

    // Read data is forwarded straight from memory in the ack cycle, then held.
    assign I_rd_data   = (i_ack_q && !wr_q) ? mem_rd_data : i_rd_q;
    assign D_rd_data   = (d_ack_q && !wr_q) ? mem_rd_data : d_rd_q;
    assign I_ack       = i_ack_q;
    assign D_ack       = d_ack_q;
    assign mem_en      = en_q;
    assign mem_wr_en   = wen_q;
    assign mem_addr    = addr_q;
    assign mem_byte_en = be_q;
    assign mem_wr_data = wdata_q;
    assign I_stall     = I_req && !i_ack_q && !Reset;
    assign D_stall     = D_req && !d_ack_q && !Reset;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter against a
// cycle-count reference model and a reference memory.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int RL = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          I_req = 1'b0;
    logic [AW-1:0] I_addr = '0;
    logic          D_req = 1'b0;
    logic          D_wr_en = 1'b0;
    logic [AW-1:0] D_addr = '0;
    logic [3:0]    D_byte_en = '0;
    logic [31:0]   D_wr_data = '0;
    logic          I_ack, D_ack, I_stall, D_stall, mem_en, mem_wr_en;
    logic [31:0]   I_rd_data, D_rd_data, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byte_en;

    always #5 Clk = ~Clk;

    mem_arbiter #(.ADDR_W(AW), .RD_LATENCY(RL)) dut (
        .Clk(Clk), .Reset(Reset),
        .I_req(I_req), .I_addr(I_addr), .I_ack(I_ack), .I_rd_data(I_rd_data),
        .D_req(D_req), .D_wr_en(D_wr_en), .D_addr(D_addr), .D_byte_en(D_byte_en),
        .D_wr_data(D_wr_data), .D_ack(D_ack), .D_rd_data(D_rd_data),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .I_stall(I_stall), .D_stall(D_stall)
    );

    // memory behind the arbiter: 16 words, two-cycle read pipeline
    logic [31:0] mem [16];
    logic [31:0] p1, p2;
    always @(posedge Clk) begin
        if (mem_en && mem_wr_en)
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        p1 <= (mem_en && !mem_wr_en) ? mem[mem_addr[5:2]] : $urandom;
        p2 <= p1;
    end
    assign mem_rd_data = p2;

    // reference model
    logic [31:0]   ref_mem [16];
    int            n, free_at, exp_ack_i, exp_ack_d, issue_cyc;
    int            total, bad;
    bit            last_d, rst_seen, lat_i, lat_d;
    bit            m_wr, m_port_d;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [31:0]   m_data, exp_rd, hold_i, hold_d;
    int            log_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Model consumes this cycle's inputs, advances one clock, checks outputs.
    task automatic cycle();
        lat_i = 1'b0;
        lat_d = 1'b0;
        if (n == issue_cyc) begin
            if (m_wr) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
            end else exp_rd = ref_mem[m_addr[5:2]];
        end
        if (Reset) begin
            free_at = n + 1; last_d = 1'b0; rst_seen = 1'b1;
            exp_ack_i = -1; exp_ack_d = -1; issue_cyc = -1;
            hold_i = '0; hold_d = '0;
        end else begin
            rst_seen = 1'b0;
            if (n >= free_at && (I_req || D_req)) begin
                m_port_d = (I_req && D_req) ? !last_d : D_req;
                last_d = m_port_d;
                m_wr = m_port_d && D_wr_en;
                m_addr = m_port_d ? D_addr : I_addr;
                m_be = m_port_d ? D_byte_en : 4'b0000;
                m_data = D_wr_data;
                issue_cyc = n + 1;
                if (m_port_d) begin
                    exp_ack_d = n + (m_wr ? 2 : 1 + RL); free_at = exp_ack_d + 1; lat_d = 1'b1;
                end else begin
                    exp_ack_i = n + 1 + RL; free_at = exp_ack_i + 1; lat_i = 1'b1;
                end
            end
        end
        @(negedge Clk);
        n++;
        if (rst_seen) begin
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wr_data, 0);
            chk("rst_mem_be", {28'd0, mem_byte_en}, 0);
        end
        chk("I_ack", {31'd0, I_ack}, {31'd0, n == exp_ack_i});
        chk("D_ack", {31'd0, D_ack}, {31'd0, n == exp_ack_d});
        chk("mem_en", {31'd0, mem_en}, {31'd0, n == issue_cyc});
        chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, n == issue_cyc && m_wr});
        if (n == issue_cyc) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_byte_en", {28'd0, mem_byte_en}, {28'd0, m_be});
            if (m_wr) chk("mem_wr_data", mem_wr_data, m_data);
        end
        if (n == exp_ack_i) hold_i = exp_rd;
        if (n == exp_ack_d && !m_wr) hold_d = exp_rd;
        chk("I_rd_data", I_rd_data, hold_i);
        chk("D_rd_data", D_rd_data, hold_d);
        chk("I_stall", {31'd0, I_stall}, {31'd0, I_req && n != exp_ack_i && !Reset});
        chk("D_stall", {31'd0, D_stall}, {31'd0, D_req && n != exp_ack_d && !Reset});
        if (I_ack) log_q.push_back(0);
        if (D_ack) log_q.push_back(1);
    endtask

    task automatic run_to_ack(input bit d, output int lat);
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!(d ? D_ack : I_ack) && lat < 20);
        chk(d ? "D_ack_seen" : "I_ack_seen", {31'd0, d ? D_ack : I_ack}, 1);
    endtask

    initial begin
        int lat, st;
        bit a_i, a_d;
        n = 0; free_at = 0; exp_ack_i = -1; exp_ack_d = -1; issue_cyc = -1;
        total = 0; bad = 0; last_d = 1'b0; rst_seen = 1'b0;
        hold_i = '0; hold_d = '0; exp_rd = '0; m_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
            ref_mem[i] = mem[i];
        end

        // reset with both requests high: stalls must stay low
        I_req = 1'b1; D_req = 1'b1;
        cycle(); cycle();
        Reset = 1'b0; I_req = 1'b0; D_req = 1'b0;
        cycle();

        // single D write
        D_req = 1'b1; D_wr_en = 1'b1; D_addr = 32'h100; D_wr_data = 32'hDEADBEEF; D_byte_en = 4'hF;
        run_to_ack(1'b1, lat);
        chk("d_wr_latency", lat, 2);
        D_req = 1'b0;
        cycle();

        // single I read, memory returns 0x13
        mem[1] = 32'h13; ref_mem[1] = 32'h13;
        I_req = 1'b1; I_addr = 32'h44;
        run_to_ack(1'b0, lat);
        chk("i_rd_latency", lat, 1 + RL);
        chk("i_rd_value", I_rd_data, 32'h13);
        I_req = 1'b0;
        cycle();

        // simultaneous requests after reset: D, I, D, I, D, I
        Reset = 1'b1;
        cycle();
        Reset = 1'b0; I_req = 1'b1; D_req = 1'b1; D_wr_en = 1'b0; D_addr = 32'h8; I_addr = 32'hC;
        log_q.delete();
        repeat (24) cycle();
        I_req = 1'b0; D_req = 1'b0;
        chk("rr_count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("rr_order", log_q[i], (i % 2 == 0) ? 1 : 0);
        cycle();

        // attributes changed after latch are ignored
        D_req = 1'b1; D_wr_en = 1'b1; D_addr = 32'h200; D_wr_data = 32'h1234_5678; D_byte_en = 4'h3;
        cycle();
        D_addr = 32'h300; D_wr_data = 32'hFFFF_FFFF; D_byte_en = 4'hC; D_wr_en = 1'b0;
        chk("addr_latched", mem_addr, 32'h200);
        run_to_ack(1'b1, lat);
        D_req = 1'b0;
        cycle();

        // reset during WAIT of a read abandons it; next tie goes to D
        I_req = 1'b1; I_addr = 32'h48;
        cycle(); cycle();
        Reset = 1'b1; I_req = 1'b0;
        cycle();
        chk("rst_wait_mem_en", {31'd0, mem_en}, 0);
        Reset = 1'b0;
        cycle(); cycle();
        log_q.delete();
        I_req = 1'b1; D_req = 1'b1; D_wr_en = 1'b0; D_addr = 32'h4;
        repeat (4) cycle();
        I_req = 1'b0; D_req = 1'b0;
        chk("tie_after_rst", log_q.size() > 0 ? log_q[0] : -1, 1);
        cycle(); cycle(); cycle();

        // D write with no byte lanes; stall high for exactly two cycles
        D_req = 1'b1; D_wr_en = 1'b1; D_byte_en = 4'h0; D_addr = 32'h10; D_wr_data = $urandom;
        st = 0;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cycle();
            #1 st += int'(D_stall);
        end
        chk("be0_ack", {31'd0, D_ack}, 1);
        chk("be0_stall_cycles", st, 2);
        D_req = 1'b0;
        cycle();

        // random traffic, attributes scrambled once latched, rare resets
        a_i = 1'b0; a_d = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (I_ack) a_i = 1'b0;
            if (D_ack) a_d = 1'b0;
            if (lat_i) I_addr = $urandom;
            if (lat_d) begin
                D_addr = $urandom; D_wr_data = $urandom; D_byte_en = 4'($urandom); D_wr_en = 1'($urandom);
            end
            if (!a_i && $urandom_range(2) == 0) begin
                a_i = 1'b1; I_addr = 32'($urandom_range(15)) << 2;
            end
            if (!a_d && $urandom_range(2) == 0) begin
                a_d = 1'b1; D_addr = 32'($urandom_range(15)) << 2;
                D_wr_en = 1'($urandom); D_byte_en = 4'($urandom); D_wr_data = $urandom;
            end
            I_req = a_i; D_req = a_d;
            Reset = ($urandom_range(99) == 0);
            cycle();
        end
        I_req = 1'b0; D_req = 1'b0; Reset = 1'b0;
        repeat (6) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
